// File: rtl/rolfmobile99_alu_host_pkg.sv
// Shared types and constants for the ALU FSM host sequencer.
package rolfmobile99_alu_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nib_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    RESP    = 3'd6
  } state_t;

  // Opcodes understood by the ALU FSM on the far side of the pins.
  localparam nib_t OP_ADD = 4'd0;
  localparam nib_t OP_SUB = 4'd1;
  localparam nib_t OP_AND = 4'd2;
  localparam nib_t OP_OR  = 4'd3;

  function automatic logic is_load(state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_OP);
  endfunction

endpackage

// File: rtl/rolfmobile99_alu_host_if.sv
// Request/response handshakes and ALU FSM pins of the host sequencer.
interface rolfmobile99_alu_host_if;
  import rolfmobile99_alu_pkg::*;

  logic req_valid;
  logic req_ready;
  nib_t req_a;
  nib_t req_b;
  nib_t req_op;
  logic rsp_valid;
  logic rsp_ready;
  nib_t rsp_alu;
  logic rsp_cout;
  logic pin_ctl;
  nib_t pin_data;
  nib_t pin_alu;
  logic pin_cout;
  logic busy;

  // The sequencer itself.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, pin_alu, pin_cout,
    output req_ready, rsp_valid, rsp_alu, rsp_cout, pin_ctl, pin_data, busy
  );

  // Whatever drives commands and sits on the ALU pins.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, pin_alu, pin_cout,
    input  req_ready, rsp_valid, rsp_alu, rsp_cout, pin_ctl, pin_data, busy
  );

endinterface

// File: rtl/rolfmobile99_alu_host_timer.sv
// Loadable down-counter that stops at zero; times setup and wait phases.
module rolfmobile99_alu_host_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/rolfmobile99_alu_host.sv
// Host sequencer: serialises A, B, opcode onto the ALU FSM pins with ctl
// strobes, waits, samples alu/cout and returns them on the response port.
//
//  state   | meaning
//  IDLE    | ready for a command, pins idle
//  LOAD_A  | operand A on pin_data, setup cycles then one strobe
//  LOAD_B  | operand B on pin_data, setup cycles then one strobe
//  LOAD_OP | opcode on pin_data, setup cycles then one strobe
//  WAIT    | pins idle while the ALU FSM settles
//  CAPTURE | alu/cout registered at the end of this cycle
//  RESP    | response held until the consumer takes it
module rolfmobile99_alu_host
  import rolfmobile99_alu_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int WAIT_CYC  = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  rolfmobile99_alu_host_if.slave  bus
);

  localparam int MAX_CYC = (SETUP_CYC > WAIT_CYC) ? SETUP_CYC : WAIT_CYC;
  localparam int CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  // Setup phase counts SETUP_CYC..1 then strobes at 0; wait counts WAIT_CYC-1..0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  nib_t             a_q;
  nib_t             b_q;
  nib_t             op_q;
  logic             accept;
  logic             timer_load;
  logic [CNT_W-1:0] timer_ld_val;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;
  logic             ctl_next;
  nib_t             data_next;

  logic             pin_ctl_q;
  nib_t             pin_data_q;
  logic             rsp_valid_q;
  nib_t             rsp_alu_q;
  logic             rsp_cout_q;
  logic             busy_q;
  logic             req_ready_q;

  rolfmobile99_alu_host_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_ld_val),
    .value      (timer_value),
    .zero       (timer_zero)
  );

  // Next-state and timer control.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    timer_load   = 1'b0;
    timer_ld_val = SETUP_LD;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          state_next = LOAD_OP;
        end
      end
      LOAD_OP: begin
        if (timer_zero) begin
          timer_load   = 1'b1;
          timer_ld_val = WAIT_LD;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (timer_zero) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pin values for the coming cycle, so the pins themselves come straight
  // from flops. The strobe cycle is the one where the counter has just hit 0.
  always_comb begin
    ctl_next  = is_load(state_next) && !timer_load && (timer_value == CNT_ONE);
    data_next = '0;
    case (state_next)
      LOAD_A:  data_next = accept ? bus.req_a : a_q;
      LOAD_B:  data_next = b_q;
      LOAD_OP: data_next = op_q;
      default: data_next = '0;
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      pin_ctl_q   <= 1'b0;
      pin_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_alu_q   <= '0;
      rsp_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state       <= state_next;
      pin_ctl_q   <= ctl_next;
      pin_data_q  <= data_next;
      rsp_valid_q <= (state_next == RESP);
      busy_q      <= (state_next != IDLE);
      req_ready_q <= (state_next == IDLE);
      if (accept) begin
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        op_q <= bus.req_op;
      end
      if (state == CAPTURE) begin
        rsp_alu_q  <= bus.pin_alu;
        rsp_cout_q <= bus.pin_cout;
      end
    end
  end

  assign bus.pin_ctl   = pin_ctl_q;
  assign bus.pin_data  = pin_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_alu   = rsp_alu_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.busy      = busy_q;
  assign bus.req_ready = req_ready_q;

endmodule
